// File: rtl/starfield_scheduler.sv
// Frame-synchronous starfield controller: queues one fade/mask command, applies it on vsync,
// steps the fade level per frame and scales the highest-priority star pixel by that level.
//
// state      | meaning
// IDLE       | level static, no fade in progress
// FADING_IN  | level rises by FADE_STEP each frame, saturating at 255
// FADING_OUT | level falls by FADE_STEP each frame, saturating at 0
module starfield_scheduler #(
  parameter int unsigned FADE_STEP  = 8,
  parameter logic [2:0]  RESET_MASK = 3'b111
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic        pixel_valid,
  input  logic [2:0]  layer_on,
  input  logic [23:0] layer_star,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic [2:0]  layer_run,
  output logic        fade_busy,
  output logic [7:0]  level,
  output logic [23:0] pixel_rgb
);

  localparam logic [1:0] OP_FADE_IN   = 2'd0;
  localparam logic [1:0] OP_FADE_OUT  = 2'd1;
  localparam logic [1:0] OP_SET_MASK  = 2'd2;
  localparam logic [8:0] STEP9        = 9'(FADE_STEP);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FADING_IN  = 2'd1,
    FADING_OUT = 2'd2
  } state_t;

  state_t      state;
  logic        pend_valid;
  logic [1:0]  pend_op;
  logic [7:0]  pend_data;
  logic [2:0]  mask;

  logic [8:0]  level_up;
  logic [8:0]  level_dn;
  logic [7:0]  up_sat;
  logic [7:0]  dn_sat;

  logic [2:0]  hit;
  logic [7:0]  s_raw;
  logic [15:0] prod;
  logic [7:0]  s_scaled;

  // 9-bit arithmetic: bit 8 flags overflow on the way up and a borrow on the way down.
  assign level_up = {1'b0, level} + STEP9;
  assign level_dn = {1'b0, level} - STEP9;
  assign up_sat   = level_up[8] ? 8'hFF : level_up[7:0];
  assign dn_sat   = level_dn[8] ? 8'h00 : level_dn[7:0];

  assign cmd_ready = ~pend_valid;
  assign fade_busy = (state != IDLE);
  assign layer_run = mask;

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      level      <= 8'h00;
      mask       <= RESET_MASK;
      pend_valid <= 1'b0;
      pend_op    <= 2'd0;
      pend_data  <= 8'h00;
    end else begin
      if (vsync && pend_valid) begin
        // Command apply owns this frame boundary; no fade step alongside it.
        pend_valid <= 1'b0;
        case (pend_op)
          OP_FADE_IN:  state <= (level == 8'hFF) ? IDLE : FADING_IN;
          OP_FADE_OUT: state <= (level == 8'h00) ? IDLE : FADING_OUT;
          OP_SET_MASK: mask  <= pend_data[2:0];
          default: begin
            level <= pend_data;
            state <= IDLE;
          end
        endcase
      end else if (vsync) begin
        case (state)
          FADING_IN: begin
            level <= up_sat;
            if (up_sat == 8'hFF) state <= IDLE;
          end
          FADING_OUT: begin
            level <= dn_sat;
            if (dn_sat == 8'h00) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // A command accepted alongside vsync lands in pending and waits for the next frame.
      if (cmd_valid && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_op    <= cmd_op;
        pend_data  <= cmd_data;
      end
    end
  end

  assign hit = layer_on & mask;

  always_comb begin
    s_raw = 8'h00;
    if (hit[0])      s_raw = layer_star[7:0];
    else if (hit[1]) s_raw = layer_star[15:8];
    else if (hit[2]) s_raw = layer_star[23:16];
  end

  assign prod     = {8'h00, s_raw} * {8'h00, level};
  assign s_scaled = (level == 8'hFF) ? s_raw : 8'(prod >> 8);

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      pixel_rgb <= 24'h000000;
    end else begin
      pixel_rgb <= pixel_valid ? {s_scaled, s_scaled, s_scaled} : 24'h000000;
    end
  end

endmodule

// File: doc/starfield_scheduler.md
# starfield_scheduler

Frame-synchronous controller sitting between the three starfield layers and the video output. It accepts fade and layer-mask commands over a valid/ready handshake and applies them only on frame boundaries. It runs a per-frame fade state machine and gates each layer's run enable. It priority-selects the active star pixel and scales it by the current fade level, producing a registered 24-bit grey pixel.

## Interface
Parameters:
- FADE_STEP, 8: level change per frame while fading (1..255).
- RESET_MASK, 3'b111: layer mask after reset.

Ports:
- pixel_clock  in  1  pixel clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  one-cycle frame-start pulse.
- pixel_valid  in  1  active-area qualifier for the current pixel.
- layer_on  in  3  per-layer star present; bit 0 = layer 1 (highest priority).
- layer_star  in  24  per-layer brightness; [7:0] = layer 1, [15:8] = layer 2, [23:16] = layer 3.
- cmd_valid  in  1  command offered.
- cmd_op  in  2  0 FADE_IN, 1 FADE_OUT, 2 SET_MASK, 3 SET_LEVEL.
- cmd_data  in  8  operand: mask in [2:0] for SET_MASK; level for SET_LEVEL; ignored otherwise.
- cmd_ready  out  1  high when no command is pending.
- layer_run  out  3  per-layer run enable (= applied mask).
- fade_busy  out  1  high in the FADING_IN and FADING_OUT states.
- level  out  8  current fade level.
- pixel_rgb  out  24  {s,s,s} scaled star brightness.

## Operation
- Reset values:
  - state = IDLE, level = 0, mask and layer_run = RESET_MASK.
  - pending empty, cmd_ready = 1, fade_busy = 0, pixel_rgb = 0.
- Handshake:
  - A command is accepted on a cycle where cmd_valid and cmd_ready are both high.
  - op and data are latched into the pending register.
  - cmd_ready drops the next cycle.
  - Only one command can be pending at a time. cmd_valid while cmd_ready is low is ignored and must be held by the sender.
- Apply, on the first vsync strictly after acceptance:
  - FADE_IN: state becomes FADING_IN, or stays/becomes IDLE if level is already 255.
  - FADE_OUT: state becomes FADING_OUT, or IDLE if level is already 0.
  - SET_MASK: mask = cmd_data[2:0]; state and level unchanged.
  - SET_LEVEL: level = cmd_data; state = IDLE, aborting any fade.
  - The pending register clears and cmd_ready returns high on the cycle after that vsync.
- A fade command that arrives mid-fade replaces the direction. Fading continues from the current level; there is no restart.
- Fade step, on a vsync where state was already FADING_* before that edge and no command is being applied:
  - FADING_IN: level = min(level + FADE_STEP, 255). Reaching 255 moves to IDLE.
  - FADING_OUT: level = max(level - FADE_STEP, 0). Reaching 0 moves to IDLE.
  - Arithmetic is done 9 bits wide, then saturated.
- Pixel path:
  - s_raw = layer_star byte of the lowest-index i with layer_on[i] & mask[i]; 0 if there is none.
  - s = s_raw when level = 255, else (s_raw * level) >> 8, using a 16-bit product.
  - s is forced to 0 when pixel_valid = 0.
- layer_run mirrors the mask register and changes only on vsync.

## Timing
- pixel_rgb has 1-cycle latency from layer_on, layer_star and pixel_valid. It uses the level and mask values present in the same cycle as those inputs.
- level, state, mask and layer_run update on the vsync edge itself; the new values are visible the cycle after vsync is sampled high.
- When vsync is high in the same cycle a command is accepted, the command is not applied at that vsync. It is applied at the next one.
- A vsync with an empty pending register only performs the fade step.
- A command apply and a fade step never both occur on one vsync; the apply wins.
- When vsync is high on consecutive cycles, each cycle counts as a frame boundary.
- Reset asserted mid-fade or with a command pending returns every output to its reset value asynchronously. The pending command is discarded.

## Test plan
- Reset, then FADE_IN with FADE_STEP=8:
  - Accept the command, then pulse vsync.
  - fade_busy = 1 and level stays 0.
  - Over the next 32 vsyncs level climbs 8, 16, …, 248, 255.
  - state returns to IDLE and fade_busy = 0 after the 32nd.
- Handshake:
  - Accept SET_LEVEL 0x80 with cmd_ready then low for 10 cycles with no vsync.
  - A second cmd_valid is not accepted.
  - vsync → level = 0x80, and cmd_ready = 1 the next cycle.
- Priority and scaling at level 0x80:
  - Inputs: layer_on = 3'b110, layer_star = {0x40, 0xFF, 0x10}, pixel_valid = 1.
  - One cycle later pixel_rgb = 0x7F7F7F.
  - After SET_MASK 3'b101 and a vsync: pixel_rgb = 0x202020, and layer_run = 3'b101.
- Same-cycle accept and vsync:
  - SET_MASK 0 accepted in the same cycle as vsync → layer_run is unchanged.
  - It changes to 0 at the next vsync.
- Direction reversal:
  - During FADING_IN at level 0x40, apply FADE_OUT.
  - Level holds at 0x40 on the applying vsync, then 0x38, 0x30, … down to 0.
- Reset mid-fade:
  - Assert reset at level 0x90 while FADING_OUT with a command pending.
  - Immediately: level = 0, cmd_ready = 1, layer_run = 3'b111, pixel_rgb = 0.
